// File: rtl/rib_wdt.sv
// Watchdog timer slave on the RIB interconnect: a down-counter that warns via
// a level interrupt on first expiry and requests a fixed-length SoC reset on the second.
//
// state | meaning
// ------+------------------------------------------------------------
// OFF   | disabled, counter and prescaler idle
// RUN   | counting, no expiry since the last feed/enable
// WARN  | first expiry seen, INT_PEND raised, counting toward bite
// BITE  | wdt_rst_o asserted for RST_PULSE_LEN cycles, counting frozen
module rib_wdt #(
   parameter int unsigned DIV           = 1,
   parameter int unsigned RST_PULSE_LEN = 16,
   parameter logic [31:0] FEED_KEY      = 32'h5A5AA5A5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        int_sig_o,
   output logic        wdt_rst_o
);

   localparam int unsigned PRW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned PLW = $clog2(RST_PULSE_LEN + 1);
   localparam logic [PRW-1:0] PRESC_MAX = PRW'(DIV - 1);
   localparam logic [PLW-1:0] PULSE_MAX = PLW'(RST_PULSE_LEN - 1);

   typedef enum logic [1:0] {
      S_OFF  = 2'd0,
      S_RUN  = 2'd1,
      S_WARN = 2'd2,
      S_BITE = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nx;

   logic             en;
   logic             int_en;
   logic             rst_en;
   logic             lock;
   logic             int_pend;
   logic [31:0]      load;
   logic [31:0]      count;
   logic [PRW-1:0]   presc;
   logic [PLW-1:0]   pulse_cnt;

   logic             sel_ctrl;
   logic             sel_load;
   logic             sel_count;
   logic             sel_feed;
   logic             ctrl_ok;
   logic             w1c;
   logic             wr_load;
   logic             feed;
   logic             active;
   logic             tick;
   logic             cnt_zero;

   logic             do_reload;
   logic             do_dec;
   logic             presc_clr;
   logic             set_pend;
   logic             clr_pend;
   logic             pulse_load;

   // Only the word offset is decoded; the region bits belong to the interconnect.
   logic             unused_addr;
   assign unused_addr = ^addr_i[31:4];

   assign sel_ctrl  = (addr_i[3:0] == 4'h0);
   assign sel_load  = (addr_i[3:0] == 4'h4);
   assign sel_count = (addr_i[3:0] == 4'h8);
   assign sel_feed  = (addr_i[3:0] == 4'hC);

   assign ctrl_ok  = we_i && sel_ctrl && !lock && (state != S_BITE);
   assign w1c      = we_i && sel_ctrl && data_i[4] && (state != S_BITE);
   assign wr_load  = we_i && sel_load && !lock;
   assign feed     = we_i && sel_feed && (data_i == FEED_KEY);

   assign active   = (state == S_RUN) || (state == S_WARN);
   assign tick     = active && (presc == PRESC_MAX);
   assign cnt_zero = (count == 32'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_OFF;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      do_reload  = 1'b0;
      do_dec     = 1'b0;
      presc_clr  = 1'b0;
      set_pend   = 1'b0;
      clr_pend   = 1'b0;
      pulse_load = 1'b0;
      case (state)
         S_OFF: begin
            if (ctrl_ok && data_i[0]) begin
               state_nx  = S_RUN;
               do_reload = 1'b1;
               presc_clr = 1'b1;
            end
         end
         S_RUN, S_WARN: begin
            // Disable beats feed beats tick; a feed on the zero tick avoids expiry.
            if (ctrl_ok && !data_i[0]) begin
               state_nx  = S_OFF;
               presc_clr = 1'b1;
            end else if (feed) begin
               state_nx  = S_RUN;
               do_reload = 1'b1;
               presc_clr = 1'b1;
               clr_pend  = 1'b1;
            end else if (tick) begin
               if (!cnt_zero) begin
                  do_dec = 1'b1;
               end else if (state == S_RUN) begin
                  state_nx  = S_WARN;
                  do_reload = 1'b1;
                  set_pend  = 1'b1;
               end else if (rst_en) begin
                  state_nx   = S_BITE;
                  do_reload  = 1'b1;
                  clr_pend   = 1'b1;
                  pulse_load = 1'b1;
               end else begin
                  do_reload = 1'b1;
               end
            end
         end
         S_BITE: begin
            if (pulse_cnt == '0) begin
               state_nx  = S_RUN;
               presc_clr = 1'b1;
            end
         end
         default: state_nx = S_OFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         en     <= 1'b0;
         int_en <= 1'b0;
         rst_en <= 1'b0;
         lock   <= 1'b0;
      end else if (ctrl_ok) begin
         en     <= data_i[0];
         int_en <= data_i[1];
         rst_en <= data_i[2];
         lock   <= data_i[3];
      end
   end

   // Hardware set outranks a coincident write-1-clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         int_pend <= 1'b0;
      end else if (set_pend) begin
         int_pend <= 1'b1;
      end else if (clr_pend || w1c) begin
         int_pend <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         load <= 32'hFFFF_FFFF;
      end else if (wr_load) begin
         load <= data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 32'hFFFF_FFFF;
      end else if (do_reload) begin
         count <= load;
      end else if (do_dec) begin
         count <= count - 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
      end else if (presc_clr) begin
         presc <= '0;
      end else if (active) begin
         presc <= tick ? '0 : presc + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pulse_cnt <= '0;
      end else if (pulse_load) begin
         pulse_cnt <= PULSE_MAX;
      end else if ((state == S_BITE) && (pulse_cnt != '0)) begin
         pulse_cnt <= pulse_cnt - 1'b1;
      end
   end

   always_comb begin
      int_sig_o = int_pend & int_en;
      wdt_rst_o = (state == S_BITE);
      data_o    = 32'd0;
      if (sel_ctrl) begin
         data_o = {27'd0, int_pend, lock, rst_en, int_en, en};
      end else if (sel_load) begin
         data_o = load;
      end else if (sel_count) begin
         data_o = count;
      end
   end

endmodule

// File: tb/tb_rib_wdt.sv
// Directed bench for rib_wdt: one instance at DIV=1 and one at DIV=4 share the bus
// stimulus; each scenario starts from reset and checks the relevant instance.
module tb_rib_wdt;

   localparam logic [31:0] KEY     = 32'h5A5AA5A5;
   localparam logic [31:0] BASE    = 32'h3000_0000;
   localparam logic [31:0] A_CTRL  = BASE + 32'h0;
   localparam logic [31:0] A_LOAD  = BASE + 32'h4;
   localparam logic [31:0] A_COUNT = BASE + 32'h8;
   localparam logic [31:0] A_FEED  = BASE + 32'hC;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata1, rdata4;
   logic        irq1, irq4, bite1, bite4;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rib_wdt #(.DIV(1), .RST_PULSE_LEN(16), .FEED_KEY(KEY)) u_wdt_d1 (
      .clk(clk), .rst(rst), .we_i(we), .addr_i(addr), .data_i(wdata),
      .data_o(rdata1), .int_sig_o(irq1), .wdt_rst_o(bite1)
   );

   rib_wdt #(.DIV(4), .RST_PULSE_LEN(16), .FEED_KEY(KEY)) u_wdt_d4 (
      .clk(clk), .rst(rst), .we_i(we), .addr_i(addr), .data_i(wdata),
      .data_o(rdata4), .int_sig_o(irq4), .wdt_rst_o(bite4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      we    = 1'b1;
      addr  = a;
      wdata = d;
      @(negedge clk);
      we    = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rd1(input logic [31:0] a, input string tag, input logic [31:0] exp);
      addr = a;
      #1;
      check(tag, rdata1, exp);
   endtask

   task automatic rd4(input logic [31:0] a, input string tag, input logic [31:0] exp);
      addr = a;
      #1;
      check(tag, rdata4, exp);
   endtask

   initial begin
      int hi;
      rst = 1'b1; we = 1'b0; addr = 32'd0; wdata = 32'd0;
      @(negedge clk);
      rst = 1'b0;

      // reset values
      rd1(A_CTRL,  "rst_ctrl",  32'h0);
      rd1(A_LOAD,  "rst_load",  32'hFFFF_FFFF);
      rd1(A_COUNT, "rst_count", 32'hFFFF_FFFF);
      rd1(A_FEED,  "rst_feed",  32'h0);
      rd1(BASE + 32'h2, "undecoded_rd", 32'h0);
      check("rst_irq",  irq1,  1'b0);
      check("rst_bite", bite1, 1'b0);

      // warning interrupt at DIV=4: enable at P0, ticks every 4th edge, expiry at P44
      do_reset();
      wr(A_LOAD, 32'd10);
      wr(A_CTRL, 32'h3);
      idle(39);
      rd4(A_COUNT, "d4_count_p39", 32'd1);
      idle(1);
      rd4(A_COUNT, "d4_count_p40", 32'd0);
      idle(3);
      check("d4_irq_p43", irq4, 1'b0);
      idle(1);
      check("d4_irq_p44", irq4, 1'b1);
      rd4(A_CTRL,  "d4_ctrl_p44",  32'h13);
      rd4(A_COUNT, "d4_count_p44", 32'd10);
      wr(A_CTRL, 32'h13);
      check("d4_irq_w1c", irq4, 1'b0);
      rd4(A_CTRL, "d4_ctrl_w1c", 32'h3);

      // bite at DIV=1: warn at P6, bite from P12 for 16 cycles, then RUN
      do_reset();
      wr(A_LOAD, 32'd5);
      wr(A_CTRL, 32'h7);
      idle(5);
      rd1(A_COUNT, "bite_count_p5", 32'd0);
      check("bite_irq_p5", irq1, 1'b0);
      idle(1);
      rd1(A_CTRL,  "bite_ctrl_p6",  32'h17);
      rd1(A_COUNT, "bite_count_p6", 32'd5);
      idle(5);
      check("bite_rst_p11", bite1, 1'b0);
      idle(1);
      check("bite_rst_p12", bite1, 1'b1);
      rd1(A_CTRL, "bite_ctrl_p12", 32'h7);
      hi = 1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bite1) hi++;
         else break;
      end
      check("bite_len", hi, 16);
      rd1(A_COUNT, "bite_count_after", 32'd5);
      rd1(A_CTRL,  "bite_ctrl_after",  32'h7);
      idle(1);
      rd1(A_COUNT, "bite_run_dec", 32'd4);

      // valid feed in WARN: reload, clear pend, back to RUN (next expiry only warns)
      do_reset();
      wr(A_LOAD, 32'd5);
      wr(A_CTRL, 32'h7);
      idle(6);
      rd1(A_CTRL, "feed_warn", 32'h17);
      wr(A_FEED, KEY);
      rd1(A_COUNT, "feed_count", 32'd5);
      rd1(A_CTRL,  "feed_ctrl",  32'h7);
      idle(6);
      rd1(A_CTRL, "feed_rewarn", 32'h17);
      check("feed_nobite", bite1, 1'b0);

      // wrong key in WARN: ignored, bite on schedule at P12
      do_reset();
      wr(A_LOAD, 32'd5);
      wr(A_CTRL, 32'h7);
      idle(6);
      wr(A_FEED, 32'h1234_5678);
      rd1(A_COUNT, "badkey_count", 32'd4);
      rd1(A_CTRL,  "badkey_ctrl",  32'h17);
      idle(4);
      check("badkey_p11", bite1, 1'b0);
      idle(1);
      check("badkey_bite", bite1, 1'b1);

      // feed on the zero tick wins: no INT_PEND
      do_reset();
      wr(A_LOAD, 32'd5);
      wr(A_CTRL, 32'h7);
      idle(5);
      rd1(A_COUNT, "zfeed_zero", 32'd0);
      wr(A_FEED, KEY);
      rd1(A_CTRL,  "zfeed_ctrl",  32'h7);
      rd1(A_COUNT, "zfeed_count", 32'd5);

      // hardware set beats coincident W1C (RST_EN off)
      do_reset();
      wr(A_LOAD, 32'd5);
      wr(A_CTRL, 32'h3);
      idle(5);
      wr(A_CTRL, 32'h13);
      rd1(A_CTRL, "setwins_ctrl", 32'h13);
      check("setwins_irq", irq1, 1'b1);

      // LOAD=0: warn on first tick, bite on second
      do_reset();
      wr(A_LOAD, 32'd0);
      wr(A_CTRL, 32'h7);
      idle(1);
      rd1(A_CTRL, "load0_warn", 32'h17);
      idle(1);
      check("load0_bite", bite1, 1'b1);

      // disable in RUN retains COUNT and stops counting
      do_reset();
      wr(A_LOAD, 32'd10);
      wr(A_CTRL, 32'h1);
      idle(2);
      wr(A_CTRL, 32'h0);
      rd1(A_COUNT, "dis_count", 32'd8);
      idle(3);
      rd1(A_COUNT, "dis_hold", 32'd8);
      wr(A_LOAD, 32'd7);
      rd1(A_COUNT, "load_no_touch", 32'd8);

      // lock: CTRL/LOAD writes ignored, feed works, W1C works, rst unlocks
      do_reset();
      wr(A_LOAD, 32'd20);
      wr(A_CTRL, 32'hF);
      wr(A_LOAD, 32'd3);
      wr(A_CTRL, 32'h0);
      rd1(A_LOAD,  "lock_load",  32'd20);
      rd1(A_CTRL,  "lock_ctrl",  32'hF);
      rd1(A_COUNT, "lock_count", 32'd18);
      wr(A_FEED, KEY);
      rd1(A_COUNT, "lock_feed", 32'd20);
      idle(21);
      rd1(A_CTRL, "lock_warn", 32'h1F);
      check("lock_irq", irq1, 1'b1);
      wr(A_CTRL, 32'h10);
      rd1(A_CTRL, "lock_w1c", 32'hF);
      do_reset();
      rd1(A_CTRL, "lock_rst", 32'h0);
      wr(A_CTRL, 32'h2);
      rd1(A_CTRL, "unlock_wr", 32'h2);

      // reset on the 5th cycle of the bite pulse
      do_reset();
      wr(A_LOAD, 32'd5);
      wr(A_CTRL, 32'h7);
      idle(16);
      check("midbite_on", bite1, 1'b1);
      do_reset();
      check("midbite_off", bite1, 1'b0);
      rd1(A_CTRL,  "midbite_ctrl",  32'h0);
      rd1(A_LOAD,  "midbite_load",  32'hFFFF_FFFF);
      rd1(A_COUNT, "midbite_count", 32'hFFFF_FFFF);
      idle(3);
      rd1(A_COUNT, "midbite_off_hold", 32'hFFFF_FFFF);
      check("midbite_stays_off", bite1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rib_wdt.md
Name: rib_wdt

Overview:
- Watchdog timer slave for the RIB interconnect; the bus decodes the block's 4-bit region in addr_i[31:28].
- Counts down from a programmed reload value.
  - First expiry: raises a level interrupt into the core's int_i vector.
  - Second expiry without a feed: emits a fixed-length reset request pulse for the SoC reset logic.
- Register access uses the same we_i/addr_i/data_i/data_o slave interface as timer/uart/gpio.

Parameters:
- DIV, 1, clock cycles per watchdog tick (>=1); prescaler counts 0..DIV-1.
- RST_PULSE_LEN, 16, wdt_rst_o high time in clk cycles (>=1).
- FEED_KEY, 32'h5A5AA5A5, value that must be written to FEED to reload.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- we_i  in  1  write strobe from RIB, one write per cycle when high
- addr_i  in  32  byte address; only addr_i[3:0] decoded (word offsets 0x0/0x4/0x8/0xC)
- data_i  in  32  write data
- data_o  out  32  read data, combinational from addr_i
- int_sig_o  out  1  level interrupt = CTRL.INT_PEND & CTRL.INT_EN
- wdt_rst_o  out  1  reset request pulse

Behaviour:
- Registers:
  - 0x0 CTRL: [0] EN, [1] INT_EN, [2] RST_EN, [3] LOCK, [4] INT_PEND (read; write-1-clears), other bits read 0.
  - 0x4 LOAD: reload value, RW.
  - 0x8 COUNT: RO current count.
  - 0xC FEED: WO, reads 0.
  - Undecoded offsets read 0, writes ignored.
- Reset (rst=1 at posedge):
  - CTRL=0, LOAD=COUNT=32'hFFFFFFFF, prescaler=0, pulse counter=0, state=OFF.
  - int_sig_o=0, wdt_rst_o=0.
- Register write timing: a write takes effect at the same posedge it is sampled; a read returns the updated value from the next cycle on.
- FSM states: OFF, RUN, WARN, BITE.
  - OFF: no counting. A write setting EN 0->1 loads COUNT=LOAD, clears prescaler, -> RUN.
  - RUN: tick when prescaler==DIV-1 (prescaler wraps to 0).
    - On tick with COUNT!=0: COUNT-=1.
    - On tick with COUNT==0: INT_PEND=1, COUNT=LOAD, -> WARN.
  - WARN: counts as in RUN.
    - On tick with COUNT==0 and RST_EN=1: -> BITE, wdt_rst_o=1 from next cycle, COUNT=LOAD, INT_PEND=0.
    - On tick with COUNT==0 and RST_EN=0: COUNT=LOAD, stay WARN.
  - BITE: counting frozen. wdt_rst_o held high exactly RST_PULSE_LEN cycles, then -> RUN with prescaler=0. FEED and CTRL writes are ignored in BITE.
- Writing EN=0 in RUN or WARN -> OFF.
  - COUNT and INT_PEND retained; prescaler cleared.
  - Re-enabling reloads COUNT.
- Feed (write FEED_KEY to 0xC in RUN or WARN):
  - Effects: COUNT=LOAD, prescaler=0, INT_PEND=0, -> RUN.
  - A non-key value is ignored. A feed in OFF is ignored.
  - A feed and a zero-tick in the same cycle: the feed wins, no expiry.
- LOAD write does not alter COUNT; it applies on the next reload.
- LOAD=0: every tick is an expiry (WARN on the first tick, BITE on the second if RST_EN=1).
- LOCK:
  - Once set, all writes to CTRL (including clearing LOCK) and LOAD are ignored, with one exception: the INT_PEND write-1-clear still works.
  - Only rst clears LOCK. FEED remains functional.
- Simultaneous INT_PEND hardware set and W1C write in the same cycle: the set wins.
- Counter arithmetic: 32-bit unsigned; never decrements below 0.
- Mid-operation rst: all state returns to reset values within that cycle, including aborting a BITE pulse.

Test Plan:
- Reset: rst=1 one cycle -> data_o reads CTRL=0, LOAD=COUNT=0xFFFFFFFF; int_sig_o=0, wdt_rst_o=0.
- Warning interrupt (DIV=4): LOAD=10, CTRL=0x3 -> COUNT reaches 0 after 40 cycles; on the next tick (cycle 44) INT_PEND=1, int_sig_o=1, COUNT=10. Write CTRL bit4=1 -> int_sig_o=0.
- Bite (DIV=1, RST_PULSE_LEN=16): LOAD=5, CTRL=0x7, no feed -> INT_PEND set at the 6th tick. wdt_rst_o high for exactly 16 cycles starting 6 ticks later; INT_PEND=0 afterwards; state returns to RUN.
- Feed (DIV=1): in WARN write 0x5A5AA5A5 to 0xC -> COUNT=LOAD, INT_PEND=0, no bite. Writing 0x12345678 instead -> bite proceeds on schedule. A feed coincident with the zero tick -> no expiry.
- Lock: CTRL=0xF, then write LOAD=3 and CTRL=0 -> both ignored (LOAD and CTRL unchanged); feeds still reload COUNT; rst clears LOCK.
- Mid-BITE reset: assert rst on the 5th cycle of the pulse -> wdt_rst_o=0 the next cycle, state OFF, all registers at reset values.
